dispense_unit: RTL

DISPENSE_UNIT -- requirements
Module: dispense_unit

---
 rtl/dispense_unit_pkg.sv | 23 ++
 rtl/dispense_timer.sv | 40 ++++
 rtl/dispense_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dispense_unit_pkg.sv
// +-----------------------------------------------------------------+
// | dispense_unit_pkg : state encoding and default timing constants  |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
`default_nettype none

package dispense_unit_pkg;

  localparam int unsigned CUP_CYCLES_DEF  = 50;
  localparam int unsigned POUR_CYCLES_DEF = 200;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DROP      = 3'd1,
    ST_CUP_HOLD  = 3'd2,
    ST_POUR      = 3'd3,
    ST_POUR_DONE = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dispense_timer.sv
// +-----------------------------------------------------------------+
// | dispense_timer : 16-bit loadable down-counter with done flag     |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
`default_nettype none

module dispense_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec_i,
  output logic        done_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 16'd0)) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 16'd0);

endmodule

`default_nettype wire

// File: rtl/dispense_unit.sv
// +-----------------------------------------------------------------+
// | dispense_unit : cup-drop / coffee-pour sequencer with fault latch |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
`default_nettype none

module dispense_unit
  import dispense_unit_pkg::*;
#(
  parameter int unsigned CUP_CYCLES  = CUP_CYCLES_DEF,
  parameter int unsigned POUR_CYCLES = POUR_CYCLES_DEF
) (
  input  logic       Clock,
  input  logic       RSTN_n,
  input  logic       place_cup,
  input  logic       release_cof,
  input  logic       cup_sense,
  output logic       cup_rdy,
  output logic       cof_rdy,
  output logic       cup_motor,
  output logic       valve_open,
  output logic       busy,
  output logic       fault,
  output logic [7:0] cups_served
);

  // Timer holds N-1 on entry so a phase lasts exactly N cycles.
  localparam logic [15:0] C_CUP_LOAD  = 16'(CUP_CYCLES - 1);
  localparam logic [15:0] C_POUR_LOAD = 16'(POUR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  served_q, served_d;
  logic        tmr_load, tmr_dec, tmr_done;
  logic [15:0] tmr_val;

  logic cup_rdy_q, cof_rdy_q, motor_q, valve_q, busy_q, fault_q;
  logic cup_rdy_d, cof_rdy_d, motor_d, valve_d, busy_d, fault_d;

  dispense_timer u_timer (
    .clk_i      (Clock),
    .rst_ni     (RSTN_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_ff @(posedge Clock or negedge RSTN_n) begin
    if (!RSTN_n) begin
      state_q   <= ST_IDLE;
      served_q  <= 8'd0;
      cup_rdy_q <= 1'b0;
      cof_rdy_q <= 1'b0;
      motor_q   <= 1'b0;
      valve_q   <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      served_q  <= served_d;
      cup_rdy_q <= cup_rdy_d;
      cof_rdy_q <= cof_rdy_d;
      motor_q   <= motor_d;
      valve_q   <= valve_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  // A missing cup in CUP_HOLD wins over a pour request: never pour onto nothing.
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    tmr_load = 1'b0;
    tmr_val  = 16'd0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (place_cup) begin
          state_d  = ST_DROP;
          tmr_load = 1'b1;
          tmr_val  = C_CUP_LOAD;
        end
      end
      ST_DROP: begin
        if (!place_cup) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = cup_sense ? ST_CUP_HOLD : ST_FAULT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CUP_HOLD: begin
        if (!cup_sense) begin
          state_d = ST_IDLE;
        end else if (release_cof) begin
          state_d  = ST_POUR;
          tmr_load = 1'b1;
          tmr_val  = C_POUR_LOAD;
        end else if (!place_cup) begin
          state_d = ST_IDLE;
        end
      end
      ST_POUR: begin
        if (tmr_done) begin
          state_d  = ST_POUR_DONE;
          served_d = served_q + 8'd1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_POUR_DONE: begin
        if (!release_cof) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    cup_rdy_d = (state_d == ST_CUP_HOLD);
    cof_rdy_d = (state_d == ST_POUR_DONE);
    motor_d   = (state_d == ST_DROP);
    valve_d   = (state_d == ST_POUR);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    fault_d   = (state_d == ST_FAULT);
  end

  assign cup_rdy     = cup_rdy_q;
  assign cof_rdy     = cof_rdy_q;
  assign cup_motor   = motor_q;
  assign valve_open  = valve_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign cups_served = served_q;

endmodule

`default_nettype wire
